// File: rtl/sym_pack_fifo.sv
// sym_pack_fifo
//  Bit-packing FIFO for the TS recorder datapath. SYM_W-bit symbols are packed
//  back-to-back, MSB first, into a circular store of DEPTH words of WORD_W bits.
//  A symbol may straddle two words, including the wrap from the last word back
//  to word 0. Reads return symbols in write order with one cycle of latency.
//
//  Stream bit p lives in word p/WORD_W at bit (WORD_W-1 - p%WORD_W).
//
// Ports
//  CLOCK           in   clock, rising edge
//  RESET           in   asynchronous active-low reset
//  WRITE_IN        in   write strobe, one symbol per high cycle
//  READ_IN         in   read strobe, one symbol per high cycle
//  DATA_IN         in   symbol to write
//  DATA_OUT        out  last symbol read (registered, held between reads)
//  OUT_VALID       out  one-cycle pulse when DATA_OUT was updated
//  FULL            out  fewer than SYM_W free bits
//  EMPTY           out  fewer than SYM_W stored bits
//  LEVEL           out  number of stored bits
//  WRITE_BITS_LEFT out  free bits left in the current write word
//  READ_BITS_LEFT  out  unread bits left in the current read word
//  W_FLAG          out  sticky: write attempted while FULL
//  R_FLAG          out  sticky: read attempted while EMPTY
//  DBG_WORDS       out  storage image, word k at [k*WORD_W +: WORD_W]
//                       (present only when SYM_PACK_DBG_EN is defined)
//
// Configuration
//  SYM_PACK_DBG_EN : adds the DBG_WORDS port; no other behavioural effect.

module sym_pack_fifo #(
    parameter int SYM_W  = 10,
    parameter int WORD_W = 32,
    parameter int DEPTH  = 11
) (
    input  logic                                CLOCK,
    input  logic                                RESET,
    input  logic                                WRITE_IN,
    input  logic                                READ_IN,
    input  logic [SYM_W-1:0]                    DATA_IN,
    output logic [SYM_W-1:0]                    DATA_OUT,
    output logic                                OUT_VALID,
    output logic                                FULL,
    output logic                                EMPTY,
    output logic [$clog2(DEPTH*WORD_W+1)-1:0]   LEVEL,
    output logic [$clog2(WORD_W+1)-1:0]         WRITE_BITS_LEFT,
    output logic [$clog2(WORD_W+1)-1:0]         READ_BITS_LEFT,
    output logic                                W_FLAG,
    output logic                                R_FLAG
`ifdef SYM_PACK_DBG_EN
    ,
    output logic [DEPTH*WORD_W-1:0]             DBG_WORDS
`endif
);

    localparam int CAP = DEPTH * WORD_W;
    localparam int LW  = $clog2(CAP + 1);
    localparam int BW  = $clog2(WORD_W + 1);
    localparam int OW  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WIN = 2 * WORD_W;

    logic [WORD_W-1:0] mem [DEPTH];

    // Bit pointers are kept as (word index, bit offset) pairs, so the modulo-CAP
    // wrap reduces to a word-index compare against DEPTH-1.
    logic [AW-1:0]  wr_word, rd_word, wr_word_nx, rd_word_nx;
    logic [OW-1:0]  wr_off, rd_off;
    logic [OW:0]    wr_sum, rd_sum;
    logic           wr_acc, rd_acc, wr_cross;
    logic [WIN-1:0] wr_mask, wr_data;
    logic [SYM_W-1:0] rd_sym;
    logic [LW-1:0]  level_nx;

    function automatic logic [AW-1:0] inc_word(input logic [AW-1:0] w);
        return (w == AW'(DEPTH - 1)) ? '0 : w + 1'b1;
    endfunction

    always_comb begin
        wr_acc     = WRITE_IN & ~FULL;
        rd_acc     = READ_IN & ~EMPTY;
        wr_word_nx = inc_word(wr_word);
        rd_word_nx = inc_word(rd_word);
        wr_sum     = {1'b0, wr_off} + (OW+1)'(SYM_W);
        rd_sum     = {1'b0, rd_off} + (OW+1)'(SYM_W);
        // Symbol spills into the following word only when it ends past this one.
        wr_cross   = wr_sum > (OW+1)'(WORD_W);
        // Two-word window: current word in the upper half, next word in the lower.
        wr_mask    = ((WIN'({SYM_W{1'b1}})) << (WIN - SYM_W)) >> wr_off;
        wr_data    = ((WIN'(DATA_IN)) << (WIN - SYM_W)) >> wr_off;
        rd_sym     = SYM_W'(({mem[rd_word], mem[rd_word_nx]} << rd_off) >> (WIN - SYM_W));

        level_nx = LEVEL;
        if (wr_acc && !rd_acc) begin
            level_nx = LEVEL + LW'(SYM_W);
        end else if (rd_acc && !wr_acc) begin
            level_nx = LEVEL - LW'(SYM_W);
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (wr_acc) begin
            mem[wr_word] <= (mem[wr_word] & ~wr_mask[WIN-1 -: WORD_W]) | wr_data[WIN-1 -: WORD_W];
            if (wr_cross) begin
                mem[wr_word_nx] <= (mem[wr_word_nx] & ~wr_mask[WORD_W-1:0]) | wr_data[WORD_W-1:0];
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            wr_word <= '0;
            wr_off  <= '0;
        end else if (wr_acc) begin
            if (wr_sum >= (OW+1)'(WORD_W)) begin
                wr_word <= wr_word_nx;
                wr_off  <= OW'(wr_sum - (OW+1)'(WORD_W));
            end else begin
                wr_off  <= OW'(wr_sum);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            rd_word   <= '0;
            rd_off    <= '0;
            DATA_OUT  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= rd_acc;
            if (rd_acc) begin
                DATA_OUT <= rd_sym;
                if (rd_sum >= (OW+1)'(WORD_W)) begin
                    rd_word <= rd_word_nx;
                    rd_off  <= OW'(rd_sum - (OW+1)'(WORD_W));
                end else begin
                    rd_off  <= OW'(rd_sum);
                end
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            LEVEL  <= '0;
            FULL   <= 1'b0;
            EMPTY  <= 1'b1;
            W_FLAG <= 1'b0;
            R_FLAG <= 1'b0;
        end else begin
            LEVEL <= level_nx;
            FULL  <= (LW'(CAP) - level_nx) < LW'(SYM_W);
            EMPTY <= level_nx < LW'(SYM_W);
            if (WRITE_IN && FULL) begin
                W_FLAG <= 1'b1;
            end
            if (READ_IN && EMPTY) begin
                R_FLAG <= 1'b1;
            end
        end
    end

    assign WRITE_BITS_LEFT = BW'(WORD_W) - BW'(wr_off);
    assign READ_BITS_LEFT  = BW'(WORD_W) - BW'(rd_off);

`ifdef SYM_PACK_DBG_EN
    for (genvar k = 0; k < DEPTH; k++) begin : g_dbg
        assign DBG_WORDS[k*WORD_W +: WORD_W] = mem[k];
    end
`endif

endmodule

// File: tb/tb_sym_pack_fifo.sv
// Testbench for sym_pack_fifo (defaults SYM_W=10, WORD_W=32, DEPTH=11).
// Directed stimulus pushes expected read symbols into a queue; a monitor on the
// falling edge pops and compares whenever OUT_VALID is seen.

module tb_sym_pack_fifo;

    localparam int SYM_W  = 10;
    localparam int WORD_W = 32;
    localparam int DEPTH  = 11;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b0;
    logic        WRITE_IN = 1'b0;
    logic        READ_IN = 1'b0;
    logic [SYM_W-1:0] DATA_IN = '0;
    logic [SYM_W-1:0] DATA_OUT;
    logic        OUT_VALID, FULL, EMPTY, W_FLAG, R_FLAG;
    logic [8:0]  LEVEL;
    logic [5:0]  WRITE_BITS_LEFT, READ_BITS_LEFT;
`ifdef SYM_PACK_DBG_EN
    logic [DEPTH*WORD_W-1:0] DBG_WORDS;
`endif

    int compared   = 0;
    int mismatched = 0;

    logic [SYM_W-1:0] exp_q [$];
    logic [SYM_W-1:0] sym_q [$];

    sym_pack_fifo #(.SYM_W(SYM_W), .WORD_W(WORD_W), .DEPTH(DEPTH)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .WRITE_IN(WRITE_IN),
        .READ_IN(READ_IN),
        .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT),
        .OUT_VALID(OUT_VALID),
        .FULL(FULL),
        .EMPTY(EMPTY),
        .LEVEL(LEVEL),
        .WRITE_BITS_LEFT(WRITE_BITS_LEFT),
        .READ_BITS_LEFT(READ_BITS_LEFT),
        .W_FLAG(W_FLAG),
        .R_FLAG(R_FLAG)
`ifdef SYM_PACK_DBG_EN
        ,
        .DBG_WORDS(DBG_WORDS)
`endif
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    // One clock of stimulus. exp_wr/exp_rd are the hand-decided acceptance
    // outcomes; an expected read queues the oldest stored symbol for the monitor.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [SYM_W-1:0] din,
                                 input bit exp_wr, input bit exp_rd);
        WRITE_IN = wr;
        READ_IN  = rd;
        DATA_IN  = din;
        if (exp_rd) exp_q.push_back(sym_q.pop_front());
        if (exp_wr) sym_q.push_back(din);
        @(posedge CLOCK);
        #1;
        WRITE_IN = 1'b0;
        READ_IN  = 1'b0;
    endtask

    task automatic checkDrained(input string name);
        @(negedge CLOCK);
        #1;
        checkOutput(name, exp_q.size(), 0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_empty"}, EMPTY, 1);
        checkOutput({tag, "_full"}, FULL, 0);
        checkOutput({tag, "_level"}, LEVEL, 0);
        checkOutput({tag, "_data_out"}, DATA_OUT, 0);
        checkOutput({tag, "_out_valid"}, OUT_VALID, 0);
        checkOutput({tag, "_w_flag"}, W_FLAG, 0);
        checkOutput({tag, "_r_flag"}, R_FLAG, 0);
        checkOutput({tag, "_wr_bits_left"}, WRITE_BITS_LEFT, 32);
        checkOutput({tag, "_rd_bits_left"}, READ_BITS_LEFT, 32);
    endtask

    task automatic doReset();
        RESET = 1'b0;
        sym_q.delete();
        exp_q.delete();
        repeat (4) @(posedge CLOCK);
        #1;
        checkResetState("reset");
        RESET = 1'b1;
    endtask

    always @(negedge CLOCK) begin
        if (OUT_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out_valid", 1, 0);
            end else begin
                checkOutput("data_out", DATA_OUT, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Test 1: reset
        doReset();

        // Test 2: eleven shifted-one symbols, then read them back
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b1, 1'b0, SYM_W'(10'h200 >> i), 1'b1, 1'b0);
        end
        checkOutput("t2_word0", dut.mem[0], 32'h80100200);
        checkOutput("t2_level", LEVEL, 110);
        checkOutput("t2_wr_bits_left", WRITE_BITS_LEFT, 18);
        checkOutput("t2_empty", EMPTY, 0);
        for (int i = 0; i <= 10; i++) begin
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1);
        end
        checkDrained("t2_drain");
        checkOutput("t2_empty_after", EMPTY, 1);
        checkOutput("t2_level_after", LEVEL, 0);
        checkOutput("t2_rd_bits_left", READ_BITS_LEFT, 18);

        // Test 3: fill to FULL, then one overflowing write
        doReset();
        for (int i = 0; i < 35; i++) begin
            applyStimulus(1'b1, 1'b0, SYM_W'(i * 29 + 3), 1'b1, 1'b0);
        end
        checkOutput("t3_full", FULL, 1);
        checkOutput("t3_level", LEVEL, 350);
        checkOutput("t3_w_flag_pre", W_FLAG, 0);
        applyStimulus(1'b1, 1'b0, 10'h3AB, 1'b0, 1'b0);
        checkOutput("t3_level_after", LEVEL, 350);
        checkOutput("t3_w_flag", W_FLAG, 1);
        checkOutput("t3_full_after", FULL, 1);

        // Test 4: read 20, write 20 across the CAP wrap, read all 35
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1);
        end
        checkDrained("t4_drain_a");
        checkOutput("t4_level_mid", LEVEL, 150);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b0, SYM_W'(10'h3FF - i * 7), 1'b1, 1'b0);
        end
        checkOutput("t4_level_full", LEVEL, 350);
        checkOutput("t4_wr_bits_left", WRITE_BITS_LEFT, 26);
        for (int i = 0; i < 35; i++) begin
            applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1);
        end
        checkDrained("t4_drain_b");
        checkOutput("t4_empty", EMPTY, 1);
        checkOutput("t4_rd_bits_left", READ_BITS_LEFT, 26);

        // Test 5: simultaneous read/write at LEVEL=10, then at EMPTY
        applyStimulus(1'b1, 1'b0, 10'h155, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 10'h0AA, 1'b1, 1'b1);
        checkOutput("t5_level_both", LEVEL, 10);
        checkOutput("t5_out_valid_both", OUT_VALID, 1);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b1);
        checkOutput("t5_empty", EMPTY, 1);
        checkOutput("t5_r_flag_pre", R_FLAG, 0);
        applyStimulus(1'b1, 1'b1, 10'h2CC, 1'b1, 1'b0);
        checkOutput("t5_level_empty", LEVEL, 10);
        checkOutput("t5_r_flag", R_FLAG, 1);
        checkOutput("t5_out_valid_rej", OUT_VALID, 0);
        checkOutput("t5_data_held", DATA_OUT, 10'h0AA);
        checkDrained("t5_drain");

        // Test 6: asynchronous reset in the middle of a write burst
        applyStimulus(1'b1, 1'b0, 10'h111, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 10'h222, 1'b1, 1'b0);
        WRITE_IN = 1'b1;
        DATA_IN  = 10'h333;
        #2;
        RESET = 1'b0;
        #1;
        checkResetState("t6_async");
        sym_q.delete();
        exp_q.delete();
        WRITE_IN = 1'b0;
        @(posedge CLOCK);
        #1;
        RESET = 1'b1;
        checkOutput("t6_level_hold", LEVEL, 0);
        applyStimulus(1'b0, 1'b1, '0, 1'b0, 1'b0);
        checkOutput("t6_r_flag", R_FLAG, 1);
        checkOutput("t6_out_valid", OUT_VALID, 0);
        checkOutput("t6_empty", EMPTY, 1);
        checkDrained("t6_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
